se_sram_srw_be_clr: RTL and testbench

//  Parametrised single-port synchronous SRAM: generic byte-lane write enables, optional output

---
 rtl/se_sram_srw_be_clr_pkg.sv | 19 +
 rtl/se_sram_srw_be_clr_clear_seq.sv | 74 +++++++
 rtl/se_sram_srw_be_clr.sv | 164 ++++++++++++++++
 tb/tb_se_sram_srw_be_clr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/se_sram_srw_be_clr_pkg.sv
// ---------------------------------------------------------------------------
// se_sram_srw_be_clr_pkg
//   Shared definitions for the se_sram family: clear-sequencer state encoding
//   and the byte-lane count helper used to size write-enable ports.
// ---------------------------------------------------------------------------
package se_sram_srw_be_clr_pkg;

  // Clear sequencer states; IDLE is terminal until the next reset.
  typedef enum logic {
    FSM_IDLE  = 1'b0,
    FSM_CLEAR = 1'b1
  } se_sram_fsm_e;

  // Number of write-enable lanes for a given word and lane width.
  function automatic int lane_count(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/se_sram_srw_be_clr_clear_seq.sv
// ---------------------------------------------------------------------------
// se_sram_srw_be_clr_clear_seq
//   Hardware clear sequencer. After reset it walks every word address once,
//   one address per enabled cycle, then parks in IDLE until the next reset.
// Ports
//   sram_clock          clock
//   sram_reset          synchronous reset, active high (restarts the walk)
//   sram_clock__enable  clock enable; low freezes state and address
//   clr_we              write strobe for the array this cycle
//   clr_addr            word address being cleared
//   init_busy           high while the walk is in progress
// ---------------------------------------------------------------------------
module se_sram_srw_be_clr_clear_seq
  import se_sram_srw_be_clr_pkg::*;
#(
  parameter int address_width  = 10,
  parameter int clear_on_reset = 1
) (
  input  logic                     sram_clock,
  input  logic                     sram_reset,
  input  logic                     sram_clock__enable,
  output logic                     clr_we,
  output logic [address_width-1:0] clr_addr,
  output logic                     init_busy
);

  localparam logic [address_width-1:0] last_addr_c = {address_width{1'b1}};
  localparam logic [address_width-1:0] zero_addr_c = {address_width{1'b0}};
  localparam logic [address_width-1:0] addr_one_c  = address_width'(1'b1);

  se_sram_fsm_e               state_r;
  se_sram_fsm_e               state_nxt_s;
  logic [address_width-1:0]   clr_addr_r;
  logic [address_width-1:0]   clr_addr_nxt_s;

  // Next-state and next-address logic for the clear walk.
  always_comb begin
    state_nxt_s    = state_r;
    clr_addr_nxt_s = clr_addr_r;
    case (state_r)
      FSM_CLEAR: begin
        clr_addr_nxt_s = clr_addr_r + addr_one_c;
        // The last address is still written this cycle; busy drops afterwards.
        if (clr_addr_r == last_addr_c) begin
          state_nxt_s = FSM_IDLE;
        end else begin
          state_nxt_s = FSM_CLEAR;
        end
      end
      FSM_IDLE: begin
        state_nxt_s = FSM_IDLE;
      end
      default: begin
        state_nxt_s = FSM_IDLE;
      end
    endcase
  end

  // State and address registers; reset wins over the clock enable.
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      state_r    <= (clear_on_reset != 0) ? FSM_CLEAR : FSM_IDLE;
      clr_addr_r <= zero_addr_c;
    end else if (sram_clock__enable) begin
      state_r    <= state_nxt_s;
      clr_addr_r <= clr_addr_nxt_s;
    end
  end

  assign init_busy = (state_r == FSM_CLEAR);
  assign clr_we    = init_busy & sram_clock__enable & ~sram_reset;
  assign clr_addr  = clr_addr_r;

endmodule

// File: rtl/se_sram_srw_be_clr.sv
// ---------------------------------------------------------------------------
// se_sram_srw_be_clr
//   Parametrised single-port synchronous SRAM with byte-lane write enables,
//   optional output pipeline register, read-valid strobe and a clear-after-
//   reset sequencer. The array itself has no reset; clear_on_reset zeroes it
//   (to clear_value) by hardware. initfile names a preload image for the
//   array, loaded by the simulation environment; it only makes sense with
//   clear_on_reset=0.
// Ports
//   sram_clock          clock, all state on posedge
//   sram_reset          synchronous reset, active high
//   sram_clock__enable  clock enable; low freezes all state incl. sequencer
//   select              access request this cycle
//   read_not_write      1 read, 0 write
//   write_enable        per-lane write enable (lane 0 = low byte)
//   address             word address
//   write_data          write data
//   data_out            read data, holds until the next read completes
//   data_out_valid      one-cycle strobe when data_out is updated
//   init_busy           clear in progress; accesses are ignored
// ---------------------------------------------------------------------------
module se_sram_srw_be_clr
  import se_sram_srw_be_clr_pkg::*;
#(
  parameter int                    address_width  = 10,
  parameter int                    data_width     = 32,
  parameter int                    byte_width     = 8,
  parameter int                    out_reg        = 0,
  parameter int                    clear_on_reset = 1,
  parameter logic [data_width-1:0] clear_value    = {data_width{1'b0}},
  parameter string                 initfile       = ""
) (
  input  logic                             sram_clock,
  input  logic                             sram_reset,
  input  logic                             sram_clock__enable,
  input  logic                             select,
  input  logic                             read_not_write,
  input  logic [data_width/byte_width-1:0] write_enable,
  input  logic [address_width-1:0]         address,
  input  logic [data_width-1:0]            write_data,
  output logic [data_width-1:0]            data_out,
  output logic                             data_out_valid,
  output logic                             init_busy
);

  localparam int depth_c = 1 << address_width;
  localparam int lanes_c = lane_count(data_width, byte_width);

  if ((data_width % byte_width) != 0) begin : g_bad_lane_width
    $error("se_sram_srw_be_clr: data_width must be a multiple of byte_width");
  end

  if ((clear_on_reset != 0) && (initfile != "")) begin : g_init_overwritten
    $warning("se_sram_srw_be_clr: initfile contents are overwritten by the clear sequencer");
  end

  logic [data_width-1:0]    mem_r [depth_c];

  logic                     clr_we_s;
  logic [address_width-1:0] clr_addr_s;
  logic                     init_busy_s;
  logic                     user_wr_s;
  logic                     rd_req_s;
  logic                     wr_en_s;
  logic [address_width-1:0] wr_addr_s;
  logic [data_width-1:0]    wr_data_s;
  logic [lanes_c-1:0]       wr_lanes_s;
  logic [data_width-1:0]    rd_data_s;
  logic                     stage_valid_s;
  logic [data_width-1:0]    stage_data_s;
  logic [data_width-1:0]    data_out_r;
  logic                     data_out_valid_r;

  se_sram_srw_be_clr_clear_seq #(
    .address_width  (address_width),
    .clear_on_reset (clear_on_reset)
  ) u_clear_seq (
    .sram_clock         (sram_clock),
    .sram_reset         (sram_reset),
    .sram_clock__enable (sram_clock__enable),
    .clr_we             (clr_we_s),
    .clr_addr           (clr_addr_s),
    .init_busy          (init_busy_s)
  );

  // User accesses are dropped entirely while the clear walk owns the array.
  assign user_wr_s = select & ~read_not_write & ~init_busy_s & sram_clock__enable & ~sram_reset;
  assign rd_req_s  = select &  read_not_write & ~init_busy_s & sram_clock__enable;
  assign rd_data_s = mem_r[address];

  // Array write port mux: clear sequencer has priority over the user port.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_addr_s  = address;
    wr_data_s  = write_data;
    wr_lanes_s = write_enable;
    if (clr_we_s) begin
      wr_en_s    = 1'b1;
      wr_addr_s  = clr_addr_s;
      wr_data_s  = clear_value;
      wr_lanes_s = {lanes_c{1'b1}};
    end else begin
      wr_en_s    = user_wr_s;
      wr_addr_s  = address;
      wr_data_s  = write_data;
      wr_lanes_s = write_enable;
    end
  end

  // Array write: only enabled lanes are updated, others keep their contents.
  always_ff @(posedge sram_clock) begin
    if (wr_en_s) begin
      for (int i = 0; i < lanes_c; i++) begin
        if (wr_lanes_s[i]) begin
          mem_r[wr_addr_s][i*byte_width +: byte_width] <= wr_data_s[i*byte_width +: byte_width];
        end
      end
    end
  end

  if (out_reg != 0) begin : g_out_reg
    logic                  s1_valid_r;
    logic [data_width-1:0] s1_data_r;

    // Array output register; holds its contents while the enable is low.
    always_ff @(posedge sram_clock) begin
      if (sram_reset) begin
        s1_valid_r <= 1'b0;
        s1_data_r  <= {data_width{1'b0}};
      end else if (sram_clock__enable) begin
        s1_valid_r <= rd_req_s;
        if (rd_req_s) begin
          s1_data_r <= rd_data_s;
        end
      end
    end

    assign stage_valid_s = s1_valid_r;
    assign stage_data_s  = s1_data_r;
  end else begin : g_no_out_reg
    assign stage_valid_s = rd_req_s;
    assign stage_data_s  = rd_data_s;
  end

  // Output register: data holds between reads, the strobe is forced low while stalled.
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      data_out_r       <= {data_width{1'b0}};
      data_out_valid_r <= 1'b0;
    end else if (sram_clock__enable) begin
      data_out_valid_r <= stage_valid_s;
      if (stage_valid_s) begin
        data_out_r <= stage_data_s;
      end
    end else begin
      data_out_valid_r <= 1'b0;
    end
  end

  assign data_out       = data_out_r;
  assign data_out_valid = data_out_valid_r;
  assign init_busy      = init_busy_s;

endmodule

// File: tb/tb_se_sram_srw_be_clr.sv
// ---------------------------------------------------------------------------
// tb_se_sram_srw_be_clr
//   Directed bench for se_sram_srw_be_clr. Three instances share clock,
//   reset, enable and the access bus; each has its own select:
//     dut_a  depth 16, out_reg=0, clear_on_reset=1
//     dut_b  depth 16, out_reg=1, clear_on_reset=1
//     dut_c  depth 16, out_reg=0, clear_on_reset=0
// ---------------------------------------------------------------------------
module tb_se_sram_srw_be_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sel_a, sel_b, sel_c;
  logic        rnw;
  logic [3:0]  we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] dout_a, dout_b, dout_c;
  logic        vld_a, vld_b, vld_c;
  logic        busy_a, busy_b, busy_c;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  se_sram_srw_be_clr #(.address_width(4), .out_reg(0), .clear_on_reset(1)) dut_a (
    .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en), .select(sel_a),
    .read_not_write(rnw), .write_enable(we), .address(addr), .write_data(wdata),
    .data_out(dout_a), .data_out_valid(vld_a), .init_busy(busy_a));

  se_sram_srw_be_clr #(.address_width(4), .out_reg(1), .clear_on_reset(1)) dut_b (
    .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en), .select(sel_b),
    .read_not_write(rnw), .write_enable(we), .address(addr), .write_data(wdata),
    .data_out(dout_b), .data_out_valid(vld_b), .init_busy(busy_b));

  se_sram_srw_be_clr #(.address_width(4), .out_reg(0), .clear_on_reset(0)) dut_c (
    .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en), .select(sel_c),
    .read_not_write(rnw), .write_enable(we), .address(addr), .write_data(wdata),
    .data_out(dout_c), .data_out_valid(vld_c), .init_busy(busy_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // sel bit 0 -> dut_a, bit 1 -> dut_b, bit 2 -> dut_c
  task automatic access(input logic [2:0] sel, input logic r, input logic [3:0] w,
                        input logic [3:0] a, input logic [31:0] d);
    sel_a = sel[0];
    sel_b = sel[1];
    sel_c = sel[2];
    rnw   = r;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    step();
    chk("rst_busy_a", {31'd0, busy_a}, 32'd1);
    chk("rst_vld_a",  {31'd0, vld_a},  32'd0);
    chk("rst_dout_a", dout_a,          32'h0);
    chk("rst_dout_b", dout_b,          32'h0);
    chk("rst_busy_c", {31'd0, busy_c}, 32'd0);

    // Clear walk: busy for exactly depth enabled cycles.
    rst = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("clear_cycles", n, 32'd16);
    chk("busy_b_done", {31'd0, busy_b}, 32'd0);

    // Every word reads back as the clear value, one strobe per read.
    for (int i = 0; i < 16; i++) begin
      access(3'b001, 1'b1, 4'hF, i[3:0], 32'hFFFF_FFFF);
      step();
      chk("clr_rd_vld",  {31'd0, vld_a}, 32'd1);
      chk("clr_rd_data", dout_a,         32'h0);
    end
    access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    chk("vld_single", {31'd0, vld_a}, 32'd0);

    // Byte-lane writes.
    access(3'b001, 1'b0, 4'hF, 4'd3, 32'hDEAD_BEEF);
    step();
    chk("wr_no_vld", {31'd0, vld_a}, 32'd0);
    access(3'b001, 1'b0, 4'b0101, 4'd3, 32'h1122_3344);
    step();
    access(3'b001, 1'b0, 4'b0000, 4'd3, 32'hFFFF_FFFF);
    step();
    access(3'b001, 1'b1, 4'h0, 4'd3, 32'h0);
    step();
    chk("lane_vld",  {31'd0, vld_a}, 32'd1);
    chk("lane_data", dout_a,         32'hDE22_BE44);
    access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);
    step();

    // out_reg=1: latency two, in-order back-to-back, write behind read.
    access(3'b010, 1'b0, 4'hF, 4'd1, 32'hA1A1_0001);
    step();
    access(3'b010, 1'b0, 4'hF, 4'd2, 32'hB2B2_0002);
    step();
    access(3'b010, 1'b0, 4'hF, 4'd3, 32'hC3C3_0003);
    step();
    access(3'b010, 1'b1, 4'h0, 4'd1, 32'h0);
    step();
    chk("p2_vld_n1", {31'd0, vld_b}, 32'd0);
    access(3'b010, 1'b1, 4'h0, 4'd2, 32'h0);
    step();
    chk("p2_vld_n2", {31'd0, vld_b}, 32'd1);
    chk("p2_data1",  dout_b,         32'hA1A1_0001);
    access(3'b010, 1'b1, 4'h0, 4'd3, 32'h0);
    step();
    chk("p2_data2",  dout_b,         32'hB2B2_0002);
    access(3'b010, 1'b0, 4'hF, 4'd3, 32'hFFFF_0000);
    step();
    chk("p2_vld_n4", {31'd0, vld_b}, 32'd1);
    chk("p2_data3",  dout_b,         32'hC3C3_0003);
    access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    chk("p2_vld_end", {31'd0, vld_b}, 32'd0);

    // Enable low for three cycles with a read in the output pipeline.
    access(3'b010, 1'b1, 4'h0, 4'd1, 32'h0);
    step();
    access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_vld", {31'd0, vld_b}, 32'd0);
    end
    en = 1'b1;
    step();
    chk("stall_resume_vld",  {31'd0, vld_b}, 32'd1);
    chk("stall_resume_data", dout_b,         32'hA1A1_0001);
    step();
    chk("stall_vld_end", {31'd0, vld_b}, 32'd0);

    // No-clear instance: usable immediately, lane merge on write.
    access(3'b100, 1'b0, 4'hF, 4'd0, 32'hCAFE_F00D);
    step();
    access(3'b100, 1'b0, 4'b1000, 4'd0, 32'h1200_0000);
    step();
    access(3'b100, 1'b1, 4'h0, 4'd0, 32'h0);
    step();
    chk("c_vld",  {31'd0, vld_c}, 32'd1);
    chk("c_data", dout_c,         32'h12FE_F00D);
    access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);

    // Reset, partial clear up to address 7, reset again mid-clear.
    rst = 1'b1;
    step();
    chk("rst2_dout_a", dout_a, 32'h0);
    chk("rst2_vld_b",  {31'd0, vld_b}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) access(3'b001, 1'b0, 4'hF, 4'd9, 32'h9999_9999);
      else        access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);
      step();
    end
    chk("mid_busy", {31'd0, busy_a}, 32'd1);
    access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);
    rst = 1'b1;
    step();
    chk("rst3_busy_a", {31'd0, busy_a}, 32'd1);
    chk("rst3_busy_c", {31'd0, busy_c}, 32'd0);
    rst = 1'b0;

    // Restarted walk with a three-cycle enable gap and writes while busy.
    n = 0;
    while (busy_a === 1'b1 && n < 60) begin
      en = (n >= 5 && n < 8) ? 1'b0 : 1'b1;
      if (n == 2)       access(3'b001, 1'b0, 4'hF, 4'd5,  32'h5555_5555);
      else if (n == 10) access(3'b001, 1'b0, 4'hF, 4'd12, 32'hCCCC_CCCC);
      else              access(3'b000, 1'b0, 4'h0, 4'h0,  32'h0);
      step();
      n++;
    end
    en = 1'b1;
    chk("restart_cycles", n, 32'd19);

    access(3'b001, 1'b1, 4'h0, 4'd3, 32'h0);
    step();
    chk("reclr_a3", dout_a, 32'h0);
    access(3'b001, 1'b1, 4'h0, 4'd5, 32'h0);
    step();
    chk("lost_wr5_vld", {31'd0, vld_a}, 32'd1);
    chk("lost_wr5", dout_a, 32'h0);
    access(3'b001, 1'b1, 4'h0, 4'd9, 32'h0);
    step();
    chk("lost_wr9", dout_a, 32'h0);
    access(3'b001, 1'b1, 4'h0, 4'd12, 32'h0);
    step();
    chk("lost_wr12", dout_a, 32'h0);
    access(3'b000, 1'b0, 4'h0, 4'h0, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
